// File: rtl/alu_instr_sequencer.sv
// Fetch/decode/execute strobe sequencer for the DataPath block (register-register ALU ops).
// Define SEQ_SINGLE_STEP_EN to add the step input, which gates every non-IDLE state transition.
module alu_instr_sequencer #(
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned OP_W     = 4
) (
   input  logic                Clock,
   input  logic                clear,
   input  logic                run,
   input  logic                mem_ready,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic                step,
`endif
   input  logic [31:0]         bus_in,
   output logic                PCout,
   output logic                MARin,
   output logic                IncPC,
   output logic                Zin,
   output logic                Zlowout,
   output logic                Zhighout,
   output logic                PCin,
   output logic                Read,
   output logic                MDRin,
   output logic                MDRout,
   output logic                IRin,
   output logic                Yin,
   output logic                HIin,
   output logic                LOin,
   output logic [NUM_REGS-1:0] Rout,
   output logic [NUM_REGS-1:0] Rin,
   output logic [OP_W-1:0]     operation,
   output logic                busy,
   output logic                done,
   output logic                err
);

   typedef enum logic [3:0] {
      StIdle,
      StT0,
      StT1,
      StT2,
      StT3,
      StT4,
      StT5,
      StT6,
      StDone
   } state_e;

   state_e      state_q, state_d;
   logic [31:15] ir_q;
   logic        err_q;
   logic        adv;

   logic [4:0]  opcode;
   logic [3:0]  ra, rb, rc;
   logic        is_long;
   logic        bad_regs;

   // Only the decoded fields of the instruction word are kept.
   logic        unused_bus;
   assign unused_bus = ^bus_in[14:0];

`ifdef SEQ_SINGLE_STEP_EN
   assign adv = step;
`else
   assign adv = 1'b1;
`endif

   assign opcode  = ir_q[31:27];
   assign ra      = ir_q[26:23];
   assign rb      = ir_q[22:19];
   assign rc      = ir_q[18:15];
   assign is_long = opcode[4];

   // Ra is a don't-care for long ops, which write HI/LO instead of a register.
   assign bad_regs = (32'(rb) >= NUM_REGS) || (32'(rc) >= NUM_REGS) ||
                     (!is_long && (32'(ra) >= NUM_REGS));

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [3:0] idx);
      logic [NUM_REGS-1:0] one;
      one = {{(NUM_REGS-1){1'b0}}, 1'b1};
      return (32'(idx) < NUM_REGS) ? (one << idx) : '0;
   endfunction

   // State register
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (run) state_d = StT0;
         StT0:   if (adv) state_d = StT1;
         StT1:   if (adv && mem_ready) state_d = StT2;
         StT2:   if (adv) state_d = StT3;
         StT3:   if (adv) state_d = bad_regs ? StDone : StT4;
         StT4:   if (adv) state_d = StT5;
         StT5:   if (adv) state_d = is_long ? StT6 : StDone;
         StT6:   if (adv) state_d = StDone;
         StDone: if (adv) state_d = run ? StT0 : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Instruction capture and sticky error flag
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         ir_q  <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q == StT2 && state_d == StT3) begin
            ir_q <= bus_in[31:15];
         end
         if (state_q == StT3 && state_d == StDone) begin
            err_q <= 1'b1;
         end else if (state_d == StT0 && state_q != StT0) begin
            err_q <= 1'b0;
         end
      end
   end

   // Moore output decode
   always_comb begin
      PCout     = 1'b0;
      MARin     = 1'b0;
      IncPC     = 1'b0;
      Zin       = 1'b0;
      Zlowout   = 1'b0;
      Zhighout  = 1'b0;
      PCin      = 1'b0;
      Read      = 1'b0;
      MDRin     = 1'b0;
      MDRout    = 1'b0;
      IRin      = 1'b0;
      Yin       = 1'b0;
      HIin      = 1'b0;
      LOin      = 1'b0;
      Rout      = '0;
      Rin       = '0;
      operation = '0;
      done      = 1'b0;
      unique case (state_q)
         StIdle: ;
         StT0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         StT1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         StT2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         StT3: begin
            Rout = reg_onehot(rb);
            Yin  = 1'b1;
         end
         StT4: begin
            Rout      = reg_onehot(rc);
            operation = OP_W'(opcode[3:0]);
            Zin       = 1'b1;
         end
         StT5: begin
            Zlowout = 1'b1;
            if (is_long) begin
               LOin = 1'b1;
            end else begin
               Rin = reg_onehot(ra);
            end
         end
         StT6: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
         end
         StDone: done = 1'b1;
         default: ;
      endcase
   end

   assign busy = (state_q != StIdle);
   assign err  = err_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench for alu_instr_sequencer: directed vector table, corner sequences,
// and a randomized run compared cycle-by-cycle against an expected-trace model.
module tb_alu_instr_sequencer;

   localparam int unsigned NR  = 8;
   localparam int unsigned OPW = 4;

   localparam logic [13:0] S_PCOUT  = 14'h2000;
   localparam logic [13:0] S_MARIN  = 14'h1000;
   localparam logic [13:0] S_INCPC  = 14'h0800;
   localparam logic [13:0] S_ZIN    = 14'h0400;
   localparam logic [13:0] S_ZLO    = 14'h0200;
   localparam logic [13:0] S_ZHI    = 14'h0100;
   localparam logic [13:0] S_PCIN   = 14'h0080;
   localparam logic [13:0] S_READ   = 14'h0040;
   localparam logic [13:0] S_MDRIN  = 14'h0020;
   localparam logic [13:0] S_MDROUT = 14'h0010;
   localparam logic [13:0] S_IRIN   = 14'h0008;
   localparam logic [13:0] S_YIN    = 14'h0004;
   localparam logic [13:0] S_HIIN   = 14'h0002;
   localparam logic [13:0] S_LOIN   = 14'h0001;

   localparam int PH_IDLE = 0;
   localparam int PH_T0   = 1;
   localparam int PH_T1   = 2;
   localparam int PH_T2   = 3;
   localparam int PH_T3   = 4;
   localparam int PH_T4   = 5;
   localparam int PH_T5   = 6;
   localparam int PH_T6   = 7;
   localparam int PH_DONE = 8;

   localparam logic [31:0] ADD_R1_R2_R3 = 32'h18918000;

   typedef struct packed {
      logic [13:0]     strb;
      logic [NR-1:0]   rout;
      logic [NR-1:0]   rin;
      logic [OPW-1:0]  op;
      logic            busy;
      logic            done;
      logic            err;
   } obs_t;

   typedef struct {
      logic        run;
      logic        mem;
      logic [31:0] bus;
      obs_t        exp;
   } step_t;

   typedef struct {
      logic [31:0]   instr;
      int            waits;
      int            exp_done_cyc;
      logic          exp_err;
      logic [3:0]    exp_op;
      logic [NR-1:0] exp_rin;
      logic          exp_hilo;
   } vec_t;

   logic            Clock;
   logic            clear;
   logic            run;
   logic            mem_ready;
   logic [31:0]     bus_in;
   logic            PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin;
   logic            Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
   logic [NR-1:0]   Rout;
   logic [NR-1:0]   Rin;
   logic [OPW-1:0]  operation;
   logic            busy;
   logic            done;
   logic            err;
   obs_t            obs;

   int n_checks;
   int n_errors;

   step_t q[$];
   logic  m_err;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   assign obs = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin,
                 Yin, HIin, LOin, Rout, Rin, operation, busy, done, err};

   alu_instr_sequencer #(
      .NUM_REGS(NR),
      .OP_W    (OPW)
   ) dut (
      .Clock    (Clock),
      .clear    (clear),
      .run      (run),
      .mem_ready(mem_ready),
`ifdef SEQ_SINGLE_STEP_EN
      .step     (1'b1),
`endif
      .bus_in   (bus_in),
      .PCout    (PCout),
      .MARin    (MARin),
      .IncPC    (IncPC),
      .Zin      (Zin),
      .Zlowout  (Zlowout),
      .Zhighout (Zhighout),
      .PCin     (PCin),
      .Read     (Read),
      .MDRin    (MDRin),
      .MDRout   (MDRout),
      .IRin     (IRin),
      .Yin      (Yin),
      .HIin     (HIin),
      .LOin     (LOin),
      .Rout     (Rout),
      .Rin      (Rin),
      .operation(operation),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected outputs of one phase, straight from the strobe table of the instruction cycle.
   function automatic obs_t model_obs(input int ph, input logic [31:0] instr, input logic err_v);
      obs_t        o;
      logic        lng;
      int unsigned ra, rb, rc;
      o   = '0;
      lng = instr[31];
      ra  = 32'(instr[26:23]);
      rb  = 32'(instr[22:19]);
      rc  = 32'(instr[18:15]);
      o.busy = (ph != PH_IDLE);
      o.err  = err_v;
      case (ph)
         PH_T0: o.strb = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
         PH_T1: o.strb = S_ZLO | S_PCIN | S_READ | S_MDRIN;
         PH_T2: o.strb = S_MDROUT | S_IRIN;
         PH_T3: begin
            o.strb = S_YIN;
            o.rout = (rb < NR) ? (NR'(1) << rb) : '0;
         end
         PH_T4: begin
            o.strb = S_ZIN;
            o.rout = (rc < NR) ? (NR'(1) << rc) : '0;
            o.op   = instr[30:27];
         end
         PH_T5: begin
            o.strb = lng ? (S_ZLO | S_LOIN) : S_ZLO;
            o.rin  = lng ? '0 : (NR'(1) << ra);
         end
         PH_T6: o.strb = S_ZHI | S_HIIN;
         PH_DONE: o.done = 1'b1;
         default: ;
      endcase
      return o;
   endfunction

   task automatic push(input int ph, input logic [31:0] instr, input logic run_v,
                       input logic mem_v);
      step_t s;
      s.exp = model_obs(ph, instr, m_err);
      s.run = run_v;
      s.mem = mem_v;
      s.bus = (ph == PH_T2) ? instr : $urandom();
      q.push_back(s);
   endtask

   task automatic build(input logic [31:0] instr, input int waits, input logic from_idle,
                        input logic run_at_done);
      logic legal;
      legal = (32'(instr[22:19]) < NR) && (32'(instr[18:15]) < NR) &&
              (instr[31] || (32'(instr[26:23]) < NR));
      if (from_idle) push(PH_IDLE, instr, 1'b1, 1'($urandom()));
      m_err = 1'b0;
      push(PH_T0, instr, 1'($urandom()), 1'($urandom()));
      for (int w = 0; w < waits; w++) push(PH_T1, instr, 1'($urandom()), 1'b0);
      push(PH_T1, instr, 1'($urandom()), 1'b1);
      push(PH_T2, instr, 1'($urandom()), 1'($urandom()));
      push(PH_T3, instr, 1'($urandom()), 1'($urandom()));
      if (legal) begin
         push(PH_T4, instr, 1'($urandom()), 1'($urandom()));
         push(PH_T5, instr, 1'($urandom()), 1'($urandom()));
         if (instr[31]) push(PH_T6, instr, 1'($urandom()), 1'($urandom()));
      end
      m_err = !legal;
      push(PH_DONE, instr, run_at_done, 1'($urandom()));
   endtask

   task automatic play(input string tag);
      step_t s;
      int    k;
      k = 0;
      while (q.size() > 0) begin
         s = q.pop_front();
         @(negedge Clock);
         check($sformatf("%s cycle%0d", tag, k), 64'(obs), 64'(s.exp));
         run       = s.run;
         mem_ready = s.mem;
         bus_in    = s.bus;
         k++;
      end
   endtask

   // Start from IDLE, pulse run, and measure the instruction by observation.
   task automatic run_vec(input vec_t v, input string tag);
      int            done_cyc, read_cyc, waited;
      logic [OPW-1:0] op_or;
      logic [NR-1:0] rin_or;
      logic          hilo, err_done;
      done_cyc = -1;
      read_cyc = 0;
      waited   = 0;
      op_or    = '0;
      rin_or   = '0;
      hilo     = 1'b0;
      err_done = 1'b0;
      @(negedge Clock);
      bus_in    = v.instr;
      mem_ready = 1'b1;
      run       = 1'b1;
      for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
         @(negedge Clock);
         run = 1'b0;
         if (Read) begin
            read_cyc++;
            mem_ready = (waited < v.waits) ? 1'b0 : 1'b1;
            if (waited < v.waits) waited++;
         end else begin
            mem_ready = 1'b1;
         end
         op_or  |= operation;
         rin_or |= Rin;
         hilo   |= HIin | LOin;
         if (done) begin
            done_cyc = c;
            err_done = err;
         end
      end
      check({tag, " done_cycle"}, 64'(done_cyc), 64'(v.exp_done_cyc));
      check({tag, " err_at_done"}, 64'(err_done), 64'(v.exp_err));
      check({tag, " operation"}, 64'(op_or), 64'(v.exp_op));
      check({tag, " rin_seen"}, 64'(rin_or), 64'(v.exp_rin));
      check({tag, " hilo_seen"}, 64'(hilo), 64'(v.exp_hilo));
      check({tag, " read_cycles"}, 64'(read_cyc), 64'(v.waits + 1));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          vecs[8];
      vec_t          ill;
      int            dc1, dc2, dcnt;
      logic          b2b_cur, b2b_next;
      logic [4:0]    opc;
      logic [3:0]    ra, rb, rc;
      logic [31:0]   instr;

      vecs[0] = '{ADD_R1_R2_R3, 0, 7, 1'b0, 4'h3, 8'h02, 1'b0};
      vecs[1] = '{ADD_R1_R2_R3, 3, 10, 1'b0, 4'h3, 8'h02, 1'b0};
      vecs[2] = '{32'h80228000, 0, 8, 1'b0, 4'h0, 8'h00, 1'b1};
      vecs[3] = '{(32'd3 << 27) | (32'd1 << 23) | (32'd2 << 19) | (32'd9 << 15), 0, 5, 1'b1,
                  4'h0, 8'h00, 1'b0};
      vecs[4] = '{(32'd3 << 27) | (32'd12 << 23) | (32'd2 << 19) | (32'd3 << 15), 2, 7, 1'b1,
                  4'h0, 8'h00, 1'b0};
      vecs[5] = '{(32'd21 << 27) | (32'd12 << 23) | (32'd3 << 19) | (32'd7 << 15), 0, 8, 1'b0,
                  4'h5, 8'h00, 1'b1};
      vecs[6] = '{(32'd16 << 27) | (32'd8 << 19) | (32'd1 << 15), 1, 6, 1'b1,
                  4'h0, 8'h00, 1'b0};
      vecs[7] = '{(32'd15 << 27) | (32'd7 << 23) | (32'd7 << 15), 1, 8, 1'b0,
                  4'hf, 8'h80, 1'b0};

      n_checks  = 0;
      n_errors  = 0;
      m_err     = 1'b0;
      clear     = 1'b0;
      run       = 1'b0;
      mem_ready = 1'b1;
      bus_in    = '0;

      repeat (3) @(negedge Clock);
      check("reset_outputs", 64'(obs), 64'(0));
      clear = 1'b1;
      @(negedge Clock);
      check("idle_after_reset", 64'(obs), 64'(0));

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // err stays set through IDLE and clears on the next T0
      ill = vecs[3];
      run_vec(ill, "sticky_setup");
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         check($sformatf("err_sticky_idle%0d", i), 64'(err), 64'(1));
      end
      bus_in = ADD_R1_R2_R3;
      run    = 1'b1;
      @(negedge Clock);
      run = 1'b0;
      check("err_clear_at_t0", 64'({err, busy, PCout}), 64'(3'b011));
      dc1 = -1;
      for (int c = 2; c <= 40 && dc1 < 0; c++) begin
         @(negedge Clock);
         if (done) dc1 = c;
      end
      check("sticky_next_done_cycle", 64'(dc1), 64'(7));

      // Reset clears a set err
      run_vec(ill, "reset_err_setup");
      @(negedge Clock);
      #2 clear = 1'b0;
      #1 check("reset_clears_err", 64'(err), 64'(0));
      @(negedge Clock);
      clear = 1'b1;

      // Reset asserted mid-instruction in T4
      @(negedge Clock);
      bus_in    = ADD_R1_R2_R3;
      mem_ready = 1'b1;
      run       = 1'b1;
      repeat (5) begin
         @(negedge Clock);
         run = 1'b0;
      end
      check("midop_at_t4", 64'({Zin, operation}), 64'({1'b1, 4'h3}));
      #2 clear = 1'b0;
      #1 check("midop_async_reset", 64'(obs), 64'(0));
      @(negedge Clock);
      check("midop_reset_held", 64'(obs), 64'(0));
      clear = 1'b1;
      @(negedge Clock);
      check("midop_idle_after_release", 64'(obs), 64'(0));
      run_vec(vecs[0], "after_reset");

      // Back-to-back with run held high
      @(negedge Clock);
      bus_in    = ADD_R1_R2_R3;
      mem_ready = 1'b1;
      run       = 1'b1;
      dc1  = -1;
      dc2  = -1;
      dcnt = 0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge Clock);
         if (done) begin
            dcnt++;
            if (dc1 < 0) dc1 = c;
            else dc2 = c;
         end
         if (c == 8) check("b2b_t0_after_done", 64'({PCout, busy}), 64'(2'b11));
         if (c == 14) run = 1'b0;
      end
      check("b2b_first_done", 64'(dc1), 64'(7));
      check("b2b_second_done", 64'(dc2), 64'(14));
      check("b2b_done_count", 64'(dcnt), 64'(2));
      @(negedge Clock);
      check("b2b_idle", 64'(busy), 64'(0));

      // Randomized trace against the model
      clear = 1'b0;
      @(negedge Clock);
      clear = 1'b1;
      m_err = 1'b0;
      b2b_cur = 1'b0;
      for (int i = 0; i < 60; i++) begin
         opc   = 5'($urandom_range(0, 31));
         ra    = 4'($urandom_range(0, 8));
         rb    = 4'($urandom_range(0, 8));
         rc    = 4'($urandom_range(0, 8));
         instr = {opc, ra, rb, rc, 15'($urandom())};
         b2b_next = (i < 59) && ($urandom_range(0, 2) == 0);
         if (!b2b_cur) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++)
               push(PH_IDLE, 32'h0, 1'b0, 1'($urandom()));
         end
         build(instr, int'($urandom_range(0, 3)), !b2b_cur, b2b_next);
         b2b_cur = b2b_next;
      end
      push(PH_IDLE, 32'h0, 1'b0, 1'b1);
      push(PH_IDLE, 32'h0, 1'b0, 1'b1);
      play("rand");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
Control sequencer for the DataPath block. It generates the per-T-state strobes for a fetch/decode/execute cycle of register-register ALU instructions, parametrised in register count.
It generalises the fixed hand-timed T0–T5 add sequence in three ways: it decodes opcode and register fields from the fetched instruction; it stalls on a memory-ready handshake; it adds a T6 state for 64-bit-result ops (MUL/DIV) that write HI/LO.
It sits beside DataPath and drives its control inputs; the datapath bus is fed back for instruction capture.

Parameters:
NUM_REGS, 16, number of general registers decoded into Rin/Rout one-hots; legal 2..16.
OP_W, 4, width of the ALU operation code driven to DataPath.

Ports:
Clock  in  1  system clock, rising edge.
clear  in  1  asynchronous, active-low reset.
run  in  1  start request; sampled in IDLE and DONE.
mem_ready  in  1  memory read data valid; T1 stalls while low.
bus_in  in  32  datapath bus; captured as IR at the end of T2.
PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes.
Rout  out  NUM_REGS  one-hot register-to-bus select.
Rin  out  NUM_REGS  one-hot register load.
operation  out  OP_W  ALU op code.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at instruction completion.
err  out  1  sticky illegal-register flag.

Behaviour:
- Reset (clear=0, asynchronous):
  - State goes to IDLE and the internal IR register clears to 0.
  - err clears to 0.
  - All strobes, Rin, Rout and operation are 0.
  - Reset asserted mid-instruction aborts immediately; no partial write completes.
- Outputs are Moore-decoded from the registered state and IR, stable for the whole cycle.
- IR fields:
  - [31:27] opcode
  - [26:23] Ra (destination)
  - [22:19] Rb
  - [18:15] Rc
- Opcode decode:
  - operation = opcode[3:0].
  - opcode[4]=1 marks a long op (MUL/DIV); Ra is ignored for long ops.
- States and strobes:
  - IDLE: all strobes 0. Goes to T0 when run=1.
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Stays in T1 while mem_ready=0; repeated PCin reloads the same Z, which is harmless.
  - T2: MDRout, IRin. bus_in is latched to the internal IR at the clock edge leaving T2.
  - T3: Rout[Rb], Yin.
    - If Rb, Rc or Ra (short ops only) is >= NUM_REGS: set err=1, skip to DONE, no register or HI/LO write.
  - T4: Rout[Rc], operation=opcode[3:0], Zin. operation is 0 in every other state.
  - T5, short op: Zlowout, Rin[Ra], then DONE.
  - T5, long op: Zlowout, LOin, then T6.
  - T6: Zhighout, HIin, then DONE.
  - DONE: done=1 for one cycle. Goes to T0 if run=1 (back-to-back), else IDLE.
- run is ignored while busy, except in DONE.
- err clears only on the T0 entry of the next instruction.
- Latency with mem_ready tied high:
  - Short op: run accepted at edge 0; T0..T5 take 6 cycles; done in cycle 7.
  - Long op: one cycle more.
  - Each low cycle of mem_ready in T1 adds one cycle.
- At most one bit of Rin is set and at most one bit of Rout is set in any cycle. Rin and Rout are never both nonzero in the same cycle.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - Every state transition except from IDLE is additionally gated by step=1 in that cycle.
  - Outputs hold while waiting, and mem_ready gating still applies.
- When undefined: the step port is absent and states advance freely as above.

Test Plan:
- ADD R1,R2,R3: bus_in=32'h18918000 at T2, mem_ready=1, run pulse -> Rout[2]&Yin in T3; Rout[3]&operation=4'h3&Zin in T4; Rin[1]&Zlowout in T5; done in cycle 7; err=0.
- Memory wait: same instruction with mem_ready low for 3 cycles in T1 -> Read, MDRin and PCin held 4 cycles; done in cycle 10; no other strobe changes.
- MUL R4,R5: bus_in=32'h80228000 -> operation=4'h0 in T4; LOin&Zlowout in T5; HIin&Zhighout in T6; Rin all 0 throughout; done in cycle 8.
- Illegal register: NUM_REGS=8, instruction with Rc=9 -> err=1 at DONE, Rin/HIin/LOin never asserted; err stays 1 until the next T0.
- Reset mid-op: drive clear=0 during T4 -> all outputs 0 asynchronously, state IDLE, busy=0; after release, a new run executes normally.
- Back-to-back: run held high -> DONE goes directly to T0; two ADDs complete in 14 cycles with two single-cycle done pulses.
